// File: rtl/multdiv_param_if.sv
// Request/result bundle for the parametrised multiply/divide unit.
// master drives operands and requests; slave returns result, flags and handshake.
interface multdiv_param_if #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_B = 16
);
    logic [WIDTH_A-1:0] data_operandA;
    logic [WIDTH_B-1:0] data_operandB;
    logic               ctrl_MULT;
    logic               ctrl_DIV;
    logic               ctrl_signed;
    logic [WIDTH_A-1:0] data_result;
    logic [WIDTH_B-1:0] data_remainder;
    logic               data_exception;
    logic               data_div0;
    logic               data_inputRDY;
    logic               data_resultRDY;

    modport master (
        output data_operandA, data_operandB,
        output ctrl_MULT, ctrl_DIV, ctrl_signed,
        input  data_result, data_remainder,
        input  data_exception, data_div0,
        input  data_inputRDY, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB,
        input  ctrl_MULT, ctrl_DIV, ctrl_signed,
        output data_result, data_remainder,
        output data_exception, data_div0,
        output data_inputRDY, data_resultRDY
    );
endinterface

// File: rtl/multdiv_param.sv
// Multi-cycle multiply (radix-4 Booth) / divide (non-restoring) unit.
// Ports: clock, ctrl_reset_n (async low), bus (slave side of multdiv_param_if).
module multdiv_param #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_B = 16
) (
    input logic            clock,
    input logic            ctrl_reset_n,
    multdiv_param_if.slave bus
);
    localparam int PW = WIDTH_A + WIDTH_B + 2;
    localparam int RW = WIDTH_B + 2;
    localparam int CW = $clog2(WIDTH_A + 2) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH_B / 2);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH_A + 1);
    localparam logic [WIDTH_A-1:0] A_MIN = {1'b1, {(WIDTH_A-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH_A-1:0] opa;
    logic [WIDTH_B-1:0] opb;
    logic               sgn;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      mcand;
    logic [WIDTH_B:0]   mq;
    logic [WIDTH_A-1:0] dq;
    logic [RW-1:0]      rem;
    logic [WIDTH_B-1:0] dvs;

    logic               accept;
    logic [PW-1:0]      booth_add;
    logic [PW-1:0]      p_full;
    logic               mul_ovf;
    logic               a_neg;
    logic               b_neg;
    logic [RW-1:0]      r_sh;
    logic [RW-1:0]      r_step;
    logic [WIDTH_B-1:0] r_fix;
    logic               div_ovf;

    assign accept = bus.data_inputRDY & (bus.ctrl_MULT ^ bus.ctrl_DIV);

    always_comb begin
        booth_add = '0;
        case (mq[2:0])
            3'b001, 3'b010: booth_add = mcand;
            3'b011:         booth_add = mcand << 1;
            3'b100:         booth_add = -(mcand << 1);
            3'b101, 3'b110: booth_add = -mcand;
            default:        booth_add = '0;
        endcase
    end

    // Unsigned mode: the zero-extended multiplier adds one more Booth digit
    // equal to the original MSB, applied in the finalize cycle.
    assign p_full = acc + ((~sgn & opb[WIDTH_B-1]) ? mcand : '0);

    always_comb begin
        if (sgn)
            mul_ovf = ~((&p_full[PW-1:WIDTH_A-1]) |
                        ~(|p_full[PW-1:WIDTH_A-1]));
        else
            mul_ovf = |p_full[PW-1:WIDTH_A];
    end

    assign a_neg   = sgn & opa[WIDTH_A-1];
    assign b_neg   = sgn & opb[WIDTH_B-1];
    assign r_sh    = {rem[RW-2:0], dq[WIDTH_A-1]};
    assign r_step  = rem[RW-1] ? r_sh + {2'b00, dvs} : r_sh - {2'b00, dvs};
    assign r_fix   = rem[RW-1] ? rem[WIDTH_B-1:0] + dvs : rem[WIDTH_B-1:0];
    assign div_ovf = sgn & (opa == A_MIN) & (&opb);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            opa                <= '0;
            opb                <= '0;
            sgn                <= 1'b0;
            acc                <= '0;
            mcand              <= '0;
            mq                 <= '0;
            dq                 <= '0;
            rem                <= '0;
            dvs                <= '0;
            bus.data_result    <= '0;
            bus.data_remainder <= '0;
            bus.data_exception <= 1'b0;
            bus.data_div0      <= 1'b0;
            bus.data_inputRDY  <= 1'b1;
            bus.data_resultRDY <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        opa                <= bus.data_operandA;
                        opb                <= bus.data_operandB;
                        sgn                <= bus.ctrl_signed;
                        cnt                <= '0;
                        acc                <= '0;
                        mcand              <= {{(PW-WIDTH_A){bus.ctrl_signed &
                                               bus.data_operandA[WIDTH_A-1]}},
                                               bus.data_operandA};
                        mq                 <= {bus.data_operandB, 1'b0};
                        bus.data_exception <= 1'b0;
                        bus.data_div0      <= 1'b0;
                        bus.data_inputRDY  <= 1'b0;
                        bus.data_resultRDY <= 1'b0;
                        state              <= bus.ctrl_MULT ? MUL : DIV;
                    end
                end
                MUL: begin
                    if (cnt != MUL_LAST) begin
                        acc   <= acc + booth_add;
                        mcand <= mcand << 2;
                        mq    <= mq >> 2;
                        cnt   <= cnt + CW'(1);
                    end else begin
                        bus.data_result    <= p_full[WIDTH_A-1:0];
                        bus.data_remainder <= '0;
                        bus.data_exception <= mul_ovf;
                        bus.data_div0      <= 1'b0;
                        bus.data_inputRDY  <= 1'b1;
                        bus.data_resultRDY <= 1'b1;
                        state              <= DONE;
                    end
                end
                DIV: begin
                    if (cnt == '0) begin
                        if (opb == '0) begin
                            bus.data_result    <= '0;
                            bus.data_remainder <= '0;
                            bus.data_exception <= 1'b1;
                            bus.data_div0      <= 1'b1;
                            bus.data_inputRDY  <= 1'b1;
                            bus.data_resultRDY <= 1'b1;
                            state              <= DONE;
                        end else begin
                            dq  <= a_neg ? -opa : opa;
                            dvs <= b_neg ? -opb : opb;
                            rem <= '0;
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt != DIV_LAST) begin
                        rem <= r_step;
                        dq  <= {dq[WIDTH_A-2:0], ~r_step[RW-1]};
                        cnt <= cnt + CW'(1);
                    end else begin
                        // min / -1 wraps back to min through the negation
                        bus.data_result    <= (a_neg ^ b_neg) ? -dq : dq;
                        bus.data_remainder <= a_neg ? -r_fix : r_fix;
                        bus.data_exception <= div_ovf;
                        bus.data_div0      <= 1'b0;
                        bus.data_inputRDY  <= 1'b1;
                        bus.data_resultRDY <= 1'b1;
                        state              <= DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_param.sv
// Directed testbench for multdiv_param (32x16 defaults).
// Each scenario task drives its own stimulus and checks results inline.
module tb_multdiv_param;
    logic clock;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    multdiv_param_if #(.WIDTH_A(32), .WIDTH_B(16)) bus ();

    multdiv_param #(.WIDTH_A(32), .WIDTH_B(16)) dut (
        .clock        (clock),
        .ctrl_reset_n (rst_n),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one request starting just after a rising edge; report the
    // edge count (after accept) at which resultRDY rose, or -1 on timeout,
    // and whether inputRDY stayed low on every edge before that.
    task automatic run_op(input logic mul, input logic sgn,
                          input logic [31:0] a, input logic [15:0] b,
                          input bit scramble,
                          output int lat, output bit busy_ok);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_signed   = sgn;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = ~mul;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.data_inputRDY !== 1'b0) busy_ok = 1'b0;
            if (scramble && k <= 5) begin
                bus.data_operandA = $urandom;
                bus.data_operandB = 16'($urandom);
                bus.ctrl_signed   = ~bus.ctrl_signed;
                bus.ctrl_DIV      = (k == 2);
            end
        end
        bus.ctrl_DIV = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (bus.data_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 00000000", bus.data_result);
        end
        n_checks++;
        if (bus.data_remainder !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_remainder: got %h want 0000", bus.data_remainder);
        end
        n_checks++;
        if ({bus.data_exception, bus.data_div0} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b%b want 00",
                     bus.data_exception, bus.data_div0);
        end
        n_checks++;
        if ({bus.data_inputRDY, bus.data_resultRDY} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b%b want 10",
                     bus.data_inputRDY, bus.data_resultRDY);
        end
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_mult_signed();
        int lat;
        bit busy_ok;
        run_op(1'b1, 1'b1, 32'd1234, 16'hFFC8, 1'b0, lat, busy_ok);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d want 9", lat);
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy_inputRDY: got %b want 1", busy_ok);
        end
        n_checks++;
        if (bus.data_result !== 32'hFFFEF210) begin
            n_fail++;
            $display("FAIL mul_1234x-56: got %h want fffef210", bus.data_result);
        end
        n_checks++;
        if ({bus.data_exception, bus.data_remainder} !== 17'h0) begin
            n_fail++;
            $display("FAIL mul_exc_rem: got %b/%h want 0/0000",
                     bus.data_exception, bus.data_remainder);
        end
        n_checks++;
        if (bus.data_inputRDY !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_done_inputRDY: got %b want 1", bus.data_inputRDY);
        end
    endtask

    task automatic test_mult_ovf();
        int lat;
        bit busy_ok;
        run_op(1'b1, 1'b1, 32'h40000000, 16'd4, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_exception, bus.data_result} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL mul_sovf: got %b/%h want 1/00000000",
                     bus.data_exception, bus.data_result);
        end
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_exception, bus.data_result} !== {1'b1, 32'hFFFF0001}) begin
            n_fail++;
            $display("FAIL mul_uovf: got %b/%h want 1/ffff0001",
                     bus.data_exception, bus.data_result);
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL mul_u_latency: got %0d want 9", lat);
        end
    endtask

    task automatic test_div();
        int lat;
        bit busy_ok;
        run_op(1'b0, 1'b1, 32'hFFFFFC18, 16'd7, 1'b0, lat, busy_ok);
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL div_latency: got %0d want 34", lat);
        end
        n_checks++;
        if (bus.data_result !== 32'hFFFFFF72) begin
            n_fail++;
            $display("FAIL div_-1000/7_q: got %h want ffffff72", bus.data_result);
        end
        n_checks++;
        if (bus.data_remainder !== 16'hFFFA) begin
            n_fail++;
            $display("FAIL div_-1000/7_r: got %h want fffa", bus.data_remainder);
        end
        n_checks++;
        if (bus.data_exception !== 1'b0) begin
            n_fail++;
            $display("FAIL div_exc: got %b want 0", bus.data_exception);
        end
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== {32'h00010001, 16'h0}) begin
            n_fail++;
            $display("FAIL div_unsigned: got %h r %h want 00010001 r 0000",
                     bus.data_result, bus.data_remainder);
        end
    endtask

    task automatic test_div0();
        int lat;
        bit busy_ok;
        run_op(1'b0, 1'b1, 32'd5, 16'd0, 1'b0, lat, busy_ok);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d want 1", lat);
        end
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== 48'h0) begin
            n_fail++;
            $display("FAIL div0_values: got %h r %h want 0 r 0",
                     bus.data_result, bus.data_remainder);
        end
        n_checks++;
        if ({bus.data_exception, bus.data_div0} !== 2'b11) begin
            n_fail++;
            $display("FAIL div0_flags: got %b%b want 11",
                     bus.data_exception, bus.data_div0);
        end
    endtask

    task automatic test_div_ovf();
        int lat;
        bit busy_ok;
        run_op(1'b0, 1'b1, 32'h80000000, 16'hFFFF, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== {32'h80000000, 16'h0}) begin
            n_fail++;
            $display("FAIL div_ovf_values: got %h r %h want 80000000 r 0000",
                     bus.data_result, bus.data_remainder);
        end
        n_checks++;
        if ({bus.data_exception, bus.data_div0} !== 2'b10) begin
            n_fail++;
            $display("FAIL div_ovf_flags: got %b%b want 10",
                     bus.data_exception, bus.data_div0);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL div_ovf_latency: got %0d want 34", lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit busy_ok;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 16'd7;
        bus.ctrl_signed   = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.data_exception, bus.data_resultRDY} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_div_flags: got %b%b want 00",
                     bus.data_exception, bus.data_resultRDY);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset_values: got %h r %h want 0 r 0",
                     bus.data_result, bus.data_remainder);
        end
        n_checks++;
        if ({bus.data_inputRDY, bus.data_resultRDY,
             bus.data_exception, bus.data_div0} !== 4'b1000) begin
            n_fail++;
            $display("FAIL async_reset_flags: got %b%b%b%b want 1000",
                     bus.data_inputRDY, bus.data_resultRDY,
                     bus.data_exception, bus.data_div0);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        run_op(1'b1, 1'b1, 32'd3, 16'd5, 1'b0, lat, busy_ok);
        n_checks++;
        if (lat !== 9 || bus.data_result !== 32'd15) begin
            n_fail++;
            $display("FAIL post_reset_mul: got %h at edge %0d want 0000000f at 9",
                     bus.data_result, lat);
        end
    endtask

    task automatic test_both_high();
        int good;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 16'd5;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        good = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_inputRDY === 1'b1 && bus.data_resultRDY === 1'b0)
                good++;
        end
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        n_checks++;
        if (good !== 5) begin
            n_fail++;
            $display("FAIL both_high_hold: got %0d idle edges want 5", good);
        end
        n_checks++;
        if (bus.data_result !== 32'h0) begin
            n_fail++;
            $display("FAIL both_high_result: got %h want 00000000", bus.data_result);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        bit busy_ok;
        run_op(1'b0, 1'b0, 32'd1000000, 16'd777, 1'b1, lat, busy_ok);
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== {32'd1287, 16'd1}) begin
            n_fail++;
            $display("FAIL div_scrambled: got %0d r %0d want 1287 r 1",
                     bus.data_result, bus.data_remainder);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL div_scrambled_latency: got %0d want 34", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busy_ok;
        run_op(1'b0, 1'b1, 32'd7, 16'hFFFE, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_result, bus.data_remainder} !== {32'hFFFFFFFD, 16'd1}) begin
            n_fail++;
            $display("FAIL div_7/-2: got %h r %h want fffffffd r 0001",
                     bus.data_result, bus.data_remainder);
        end
        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 16'hFFF7, 1'b0, lat, busy_ok);
        n_checks++;
        if ({bus.data_result, bus.data_remainder, bus.data_exception} !==
            {32'd63, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_-7x-9: got %h r %h e %b want 0000003f r 0000 e 0",
                     bus.data_result, bus.data_remainder, bus.data_exception);
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL b2b_mul_latency: got %0d want 9", lat);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.ctrl_signed   = 1'b0;
        test_reset();
        test_mult_signed();
        test_mult_ovf();
        test_div();
        test_div0();
        test_div_ovf();
        test_reset_mid();
        test_both_high();
        test_operand_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_param.md
Name: multdiv_param

Overview:
- Parametrised successor to the fixed 32x16 multi-cycle multiply/divide unit.
- Operand widths are generic, with signed or unsigned mode per operation.
- Division returns a remainder; exceptions are split into overflow and divide-by-zero.
- Sits beside the ALU in the processor datapath and uses the same inputRDY/resultRDY handshake, so the stall logic is unchanged.

Parameters:
- WIDTH_A, 32, width of operand A and of data_result (dividend / multiplicand).
- WIDTH_B, 16, width of operand B and of data_remainder (divisor / multiplier). Must be even and <= WIDTH_A.

Ports:
- clock  in  1  system clock, rising-edge active.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- data_operandA  in  WIDTH_A  operand A.
- data_operandB  in  WIDTH_B  operand B.
- ctrl_MULT  in  1  request multiply (level).
- ctrl_DIV  in  1  request divide (level).
- ctrl_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- data_result  out  WIDTH_A  product (low WIDTH_A bits) or quotient.
- data_remainder  out  WIDTH_B  division remainder; 0 after multiply.
- data_exception  out  1  overflow or divide-by-zero for the last operation.
- data_div0  out  1  last operation was divide-by-zero.
- data_inputRDY  out  1  unit can accept a request this edge.
- data_resultRDY  out  1  outputs are valid.

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE, data_result=0, data_remainder=0, data_exception=0, data_div0=0, data_inputRDY=1, data_resultRDY=0. Applies mid-operation too; the partial result is discarded.
- States: IDLE, MUL, DIV, DONE. data_inputRDY=1 only in IDLE and DONE.
- Accept: on a rising edge with data_inputRDY=1 and exactly one of ctrl_MULT/ctrl_DIV high.
  - data_operandA, data_operandB and ctrl_signed are captured.
  - data_resultRDY drops to 0 on that edge.
  - MULT goes to state MUL, DIV goes to state DIV.
- Both ctrl_MULT and ctrl_DIV high: no accept; state and outputs hold.
- Request lines held high after completion: in DONE they re-trigger a new accept on the next edge, so software deasserts them.
- While busy: ctrl_* and operand inputs are ignored.
- MUL: radix-4 Booth, WIDTH_B/2 iteration cycles plus 1 finalize cycle.
  - data_resultRDY rises at edge WIDTH_B/2+1 after accept (9 for defaults).
  - Unsigned mode: both operands zero-extended by one bit before Booth recoding.
  - Full product is WIDTH_A+WIDTH_B bits; data_result = low WIDTH_A bits.
  - data_exception=1 if the full product is not representable in WIDTH_A bits (signed or unsigned range per mode).
  - data_remainder=0.
- DIV: non-restoring on magnitudes.
  - 1 cycle sign/abs conversion, WIDTH_A iteration cycles, 1 cycle quotient/remainder sign fix.
  - data_resultRDY rises at edge WIDTH_A+2 after accept (34 for defaults).
  - Quotient truncates toward zero; the remainder takes the dividend's sign; |remainder| < |divisor|.
- Divide-by-zero (B=0, checked at accept): skip to DONE at edge 1 after accept with data_result=0, data_remainder=0, data_exception=1, data_div0=1.
- Signed overflow (A = -2^(WIDTH_A-1), B = -1): data_result = A (wrapped), data_remainder=0, data_exception=1, data_div0=0. Normal DIV latency.
- DONE: outputs held stable, data_resultRDY=1 until the next accept or reset.
- Exception flags are cleared at the next accept.

Test Plan:
- Signed MULT 1234 x -56 -> data_result=-69104, data_exception=0, data_resultRDY high exactly 9 edges after accept, data_inputRDY low during edges 1-8.
- Signed MULT 0x40000000 x 4 -> data_result=0x00000000, data_exception=1; unsigned MULT 0xFFFFFFFF x 0xFFFF -> data_result=0xFFFF0001, data_exception=1.
- Signed DIV -1000 / 7 -> data_result=-142, data_remainder=-6, data_exception=0, data_resultRDY at edge 34. Unsigned DIV 0xFFFFFFFF / 0xFFFF -> 0x00010001, remainder 0.
- DIV 5 / 0 -> data_result=0, data_remainder=0, data_exception=1, data_div0=1, data_resultRDY at edge 1. Signed DIV 0x80000000 / -1 -> data_result=0x80000000, data_exception=1, data_div0=0.
- Assert ctrl_reset_n=0 at edge 10 of a DIV -> all outputs at reset values without waiting for a clock edge. After release, MULT 3 x 5 -> 15 at edge 9.
- ctrl_MULT and ctrl_DIV both high in IDLE for 5 edges -> no accept, data_inputRDY stays 1. Change operands mid-DIV -> result still matches the operands captured at accept.
